// File: rtl/symbol_packer.sv
// Packs ce-qualified 2-bit symbols LSB-first into WIDTH-bit words.
// Words go into a show-ahead FIFO; debug strobes are counted and dropped words are flagged.
module symbol_packer #(
    parameter int WIDTH  = 18,
    parameter int ADDR_W = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              ce,
    input  logic [1:0]        din,
    input  logic              debug,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic [CNT_W-1:0]  dbg_count
);
    localparam int NSYM  = WIDTH / 2;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CW    = (NSYM > 1) ? $clog2(NSYM) : 1;

    logic [CW-1:0]                 cnt_q, cnt_d;
    logic [WIDTH-1:0]              shreg_q, shreg_d;
    logic [DEPTH-1:0][WIDTH-1:0]   mem_q, mem_d;
    logic [ADDR_W-1:0]             wptr_q, wptr_d, rptr_q, rptr_d;
    logic [ADDR_W:0]               level_q, level_d;
    logic                          ovf_q, ovf_d;
    logic [CNT_W-1:0]              dbg_q, dbg_d;

    logic             push, pop, full, do_push;
    logic [WIDTH-1:0] push_word;

    assign out_valid = (level_q != '0);
    assign out_data  = out_valid ? mem_q[rptr_q] : '0;
    assign level     = level_q;
    assign overflow  = ovf_q;
    assign dbg_count = dbg_q;

    assign full      = (level_q == (ADDR_W+1)'(DEPTH));
    assign push      = ce && (cnt_q == CW'(NSYM - 1));
    assign pop       = out_valid && out_ready;
    // A pop on the same edge frees the slot, so a full FIFO can still accept
    assign do_push   = push && (!full || pop);
    assign push_word = {din, shreg_q[WIDTH-3:0]};

    always_comb begin
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        dbg_d   = dbg_q;
        if (clr) begin
            cnt_d   = '0;
            shreg_d = '0;
            mem_d   = '0;
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
            ovf_d   = 1'b0;
            dbg_d   = '0;
        end else begin
            if (ce) begin
                for (int k = 0; k < NSYM; k++)
                    if (cnt_q == CW'(k)) shreg_d[2*k +: 2] = din;
                cnt_d = (cnt_q == CW'(NSYM - 1)) ? '0 : cnt_q + CW'(1);
            end
            if (do_push) begin
                mem_d[wptr_q] = push_word;
                wptr_d        = wptr_q + ADDR_W'(1);
            end
            if (pop)
                rptr_d = rptr_q + ADDR_W'(1);
            case ({do_push, pop})
                2'b10:   level_d = level_q + (ADDR_W+1)'(1);
                2'b01:   level_d = level_q - (ADDR_W+1)'(1);
                default: level_d = level_q;
            endcase
            if (push && !do_push)
                ovf_d = 1'b1;
            if (ce && debug && (dbg_q != '1))
                dbg_d = dbg_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            shreg_q <= '0;
            mem_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            dbg_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            dbg_q   <= dbg_d;
        end
    end
endmodule

// File: tb/tb_symbol_packer.sv
// Directed bench for symbol_packer: table-driven packing/debug rows plus
// hand sequences for overflow, full push+pop, counter saturation and mid-word reset/clr.
module tb_symbol_packer;
    localparam int WIDTH = 18, ADDR_W = 2, CNT_W = 8;

    logic clk = 0, reset = 0, clr = 0, ce = 0, debug = 0, out_ready = 0;
    logic [1:0] din = 0;
    logic [WIDTH-1:0] out_data;
    logic out_valid, overflow;
    logic [ADDR_W:0] level;
    logic [CNT_W-1:0] dbg_count;

    logic ce2 = 0, debug2 = 0;
    logic [WIDTH-1:0] out_data2;
    logic out_valid2, overflow2;
    logic [ADDR_W:0] level2;
    logic [1:0] dbg_count2;

    symbol_packer #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .clr(clr), .ce(ce), .din(din), .debug(debug),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level), .overflow(overflow), .dbg_count(dbg_count));

    symbol_packer #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .clr(clr), .ce(ce2), .din(din), .debug(debug2),
        .out_data(out_data2), .out_valid(out_valid2), .out_ready(1'b0),
        .level(level2), .overflow(overflow2), .dbg_count(dbg_count2));

    always #5 clk = ~clk;

    int errors = 0, checks = 0;

    typedef struct {
        logic        ce;
        logic [1:0]  din;
        logic        dbg;
        logic        rdy;
        logic        vld;
        logic [17:0] data;
        logic [2:0]  lvl;
        logic [7:0]  dcnt;
    } vec_t;

    vec_t tbl[$];
    logic [1:0]  syms [9];
    logic [17:0] exp_w [5];

    function automatic vec_t mk(logic c, logic [1:0] d, logic g, logic r,
                                logic v, logic [17:0] dt, logic [2:0] l, logic [7:0] n);
        vec_t t;
        t.ce = c; t.din = d; t.dbg = g; t.rdy = r;
        t.vld = v; t.data = dt; t.lvl = l; t.dcnt = n;
        return t;
    endfunction

    function automatic logic [17:0] pack(int w);
        logic [17:0] r;
        r = '0;
        for (int k = 0; k < 9; k++) r[2*k +: 2] = 2'((w + k) % 4);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] d);
        ce = 1; din = d;
        step();
        ce = 0;
    endtask

    task automatic do_clr();
        clr = 1;
        step();
        clr = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " valid"}, 32'(out_valid), 0);
        chk({tag, " data"},  32'(out_data), 0);
        chk({tag, " level"}, 32'(level), 0);
        chk({tag, " ovf"},   32'(overflow), 0);
        chk({tag, " dbg"},   32'(dbg_count), 0);
    endtask

    // Five words of all-3 into an unread FIFO, then four debug-tagged symbols
    task automatic prefill();
        out_ready = 0;
        repeat (45) send(2'd3);
        debug = 1;
        repeat (4) send(2'd2);
        debug = 0;
        chk("prefill level", 32'(level), 4);
        chk("prefill ovf", 32'(overflow), 1);
        chk("prefill dbg", 32'(dbg_count), 4);
    endtask

    initial begin
        #3;
        chk_zero("reset");
        #9 reset = 1;

        syms = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 9; i++)
            tbl.push_back(mk(1, syms[i], 0, 0, i == 8, (i == 8) ? 18'h0E4E4 : 18'h0,
                             (i == 8) ? 3'd1 : 3'd0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 18'h0, 0, 0));
        for (int i = 0; i < 9; i++) begin
            tbl.push_back(mk(1, syms[i], 0, 0, i == 8, (i == 8) ? 18'h0E4E4 : 18'h0,
                             (i == 8) ? 3'd1 : 3'd0, 0));
            tbl.push_back(mk(0, 2'd3, 0, 0, i == 8, (i == 8) ? 18'h0E4E4 : 18'h0,
                             (i == 8) ? 3'd1 : 3'd0, 0));
        end
        tbl.push_back(mk(0, 0, 0, 1, 0, 18'h0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 18'h0, 0, 1));
        tbl.push_back(mk(1, 0, 1, 0, 0, 18'h0, 0, 2));
        tbl.push_back(mk(1, 0, 1, 0, 0, 18'h0, 0, 3));
        tbl.push_back(mk(0, 0, 1, 0, 0, 18'h0, 0, 3));
        tbl.push_back(mk(0, 0, 1, 0, 0, 18'h0, 0, 3));

        foreach (tbl[i]) begin
            ce = tbl[i].ce; din = tbl[i].din; debug = tbl[i].dbg; out_ready = tbl[i].rdy;
            step();
            chk($sformatf("row%0d valid", i), 32'(out_valid), 32'(tbl[i].vld));
            chk($sformatf("row%0d data", i),  32'(out_data),  32'(tbl[i].data));
            chk($sformatf("row%0d level", i), 32'(level),     32'(tbl[i].lvl));
            chk($sformatf("row%0d ovf", i),   32'(overflow),  0);
            chk($sformatf("row%0d dbg", i),   32'(dbg_count), 32'(tbl[i].dcnt));
        end
        ce = 0; debug = 0; out_ready = 0;

        // overflow then drain
        do_clr();
        chk_zero("clr");
        repeat (45) send(2'd3);
        chk("ovf level", 32'(level), 4);
        chk("ovf flag", 32'(overflow), 1);
        chk("ovf valid", 32'(out_valid), 1);
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d valid", i), 32'(out_valid), 1);
            chk($sformatf("drain%0d data", i), 32'(out_data), 32'h3FFFF);
            step();
        end
        out_ready = 0;
        chk("drained valid", 32'(out_valid), 0);
        chk("drained level", 32'(level), 0);
        chk("drained data", 32'(out_data), 0);
        chk("drained ovf sticky", 32'(overflow), 1);

        // full FIFO with push and pop on the same edge
        do_clr();
        for (int w = 0; w < 5; w++) exp_w[w] = pack(w);
        for (int w = 0; w < 4; w++)
            for (int k = 0; k < 9; k++) send(2'((w + k) % 4));
        chk("full level", 32'(level), 4);
        chk("full head", 32'(out_data), 32'(exp_w[0]));
        for (int k = 0; k < 8; k++) send(2'((4 + k) % 4));
        out_ready = 1;
        send(2'((4 + 8) % 4));
        out_ready = 0;
        chk("pp level", 32'(level), 4);
        chk("pp ovf", 32'(overflow), 0);
        chk("pp head", 32'(out_data), 32'(exp_w[1]));
        out_ready = 1;
        for (int w = 1; w < 5; w++) begin
            chk($sformatf("order%0d valid", w), 32'(out_valid), 1);
            chk($sformatf("order%0d data", w), 32'(out_data), 32'(exp_w[w]));
            step();
        end
        out_ready = 0;
        chk("order empty", 32'(level), 0);

        // 2-bit debug counter saturation
        ce2 = 1; debug2 = 1;
        step(); step();
        chk("sat dbg 2", 32'(dbg_count2), 2);
        step();
        chk("sat dbg 3", 32'(dbg_count2), 3);
        step(); step(); step();
        chk("sat dbg hold", 32'(dbg_count2), 3);
        ce2 = 0; debug2 = 0;

        // asynchronous reset mid-word
        do_clr();
        prefill();
        #2 reset = 0;
        #1;
        chk_zero("async rst");
        #1 reset = 1;
        repeat (5) send(2'd1);
        chk("rst partial discarded", 32'(out_valid), 0);
        repeat (4) send(2'd1);
        chk("rst word valid", 32'(out_valid), 1);
        chk("rst word data", 32'(out_data), 32'h15555);
        chk("rst word level", 32'(level), 1);

        // synchronous clr mid-word
        do_clr();
        prefill();
        do_clr();
        chk_zero("sync clr");
        repeat (5) send(2'd1);
        chk("clr partial discarded", 32'(out_valid), 0);
        repeat (4) send(2'd1);
        chk("clr word valid", 32'(out_valid), 1);
        chk("clr word data", 32'(out_data), 32'h15555);
        chk("clr word level", 32'(level), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
